fixed_div_seq: RTL and testbench

//   Iterative signed fixed-point divider: quotient = (lhs << FRAC_WIDTH) / rhs, one quotient bit per clock.

---
 rtl/fixed_div_seq_pkg.sv | 51 +++++
 rtl/fixed_div_seq_if.sv | 24 ++
 rtl/fixed_div_seq.sv | 133 +++++++++++++
 tb/tb_fixed_div_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_div_seq_pkg.sv
// Shared fixed-point types, range constants and the saturation helper.
package fixed_div_seq_pkg;

   localparam int unsigned TOTAL_WIDTH_DEF = 32;
   localparam int unsigned FRAC_WIDTH_DEF  = 16;

   // Widest intermediate handled by the helpers; TOTAL_WIDTH+FRAC_WIDTH must stay <= 63.
   localparam int unsigned SAT_W = 64;

   typedef logic [TOTAL_WIDTH_DEF-1:0] fixed_t;

   typedef struct packed {
      logic [SAT_W-1:0] value;
      logic             ovf;
   } sat_t;

   // Largest representable value of a w-bit two's complement number.
   function automatic logic signed [SAT_W:0] fix_max(input int unsigned w);
      logic signed [SAT_W:0] one;
      one = (SAT_W+1)'(1);
      return (one <<< (w - 1)) - one;
   endfunction

   // Most negative representable value of a w-bit two's complement number.
   function automatic logic signed [SAT_W:0] fix_min(input int unsigned w);
      logic signed [SAT_W:0] one;
      one = (SAT_W+1)'(1);
      return -fix_max(w) - one;
   endfunction

   // Clamp a wide signed value into w bits, flagging any clamp.
   function automatic sat_t saturate(input logic signed [SAT_W:0] v, input int unsigned w);
      sat_t r;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      hi = fix_max(w);
      lo = fix_min(w);
      if (v > hi) begin
         r.value = hi[SAT_W-1:0];
         r.ovf   = 1'b1;
      end else if (v < lo) begin
         r.value = lo[SAT_W-1:0];
         r.ovf   = 1'b1;
      end else begin
         r.value = v[SAT_W-1:0];
         r.ovf   = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/fixed_div_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface fixed_div_seq_if #(
   parameter int unsigned TOTAL_WIDTH = fixed_div_seq_pkg::TOTAL_WIDTH_DEF
);
   logic                   in_valid;
   logic                   in_ready;
   logic [TOTAL_WIDTH-1:0] lhs;
   logic [TOTAL_WIDTH-1:0] rhs;
   logic                   out_valid;
   logic                   out_ready;
   logic [TOTAL_WIDTH-1:0] quotient;
   logic                   div_zero;
   logic                   overflow;

   modport master (
      output in_valid, lhs, rhs, out_ready,
      input  in_ready, out_valid, quotient, div_zero, overflow
   );

   modport slave (
      input  in_valid, lhs, rhs, out_ready,
      output in_ready, out_valid, quotient, div_zero, overflow
   );
endinterface

// File: rtl/fixed_div_seq.sv
// Iterative signed fixed-point divider: (lhs << FRAC_WIDTH) / rhs, one quotient bit per clock,
// truncated toward zero and saturated to the output width.
module fixed_div_seq
   import fixed_div_seq_pkg::*;
#(
   parameter int unsigned TOTAL_WIDTH = TOTAL_WIDTH_DEF,
   parameter int unsigned FRAC_WIDTH  = FRAC_WIDTH_DEF
) (
   input  logic           clk,
   input  logic           reset,
   fixed_div_seq_if.slave bus
);

   localparam int unsigned N  = TOTAL_WIDTH + FRAC_WIDTH;
   localparam int unsigned MW = TOTAL_WIDTH + 1;
   localparam int unsigned RW = TOTAL_WIDTH + 2;
   localparam int unsigned CW = $clog2(N);

   localparam logic signed [SAT_W:0] MAX_WIDE = fix_max(TOTAL_WIDTH);
   localparam logic signed [SAT_W:0] MIN_WIDE = fix_min(TOTAL_WIDTH);
   localparam logic [TOTAL_WIDTH-1:0] Q_MAX = MAX_WIDE[TOTAL_WIDTH-1:0];
   localparam logic [TOTAL_WIDTH-1:0] Q_MIN = MIN_WIDE[TOTAL_WIDTH-1:0];

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state;
   logic [N-1:0]    dvd;       // dividend bits shift out the top, quotient bits shift in the bottom
   logic [MW-1:0]   dvs;
   logic [RW-1:0]   rem;
   logic [CW-1:0]   cnt;
   logic            neg;
   logic            lhs_neg;
   logic            zero_div;

   logic [MW-1:0]         lhs_ext;
   logic [MW-1:0]         rhs_ext;
   logic [MW-1:0]         lhs_mag;
   logic [MW-1:0]         rhs_mag;
   logic [RW-1:0]         rem_sh;
   logic [RW-1:0]         trial;
   logic [SAT_W:0]        res_mag;
   logic signed [SAT_W:0] res_signed;
   sat_t                  sat;
   logic                  unused_bits;

   // Operand magnitudes, one restoring-division step, and sign/saturate of the finished magnitude.
   always_comb begin
      lhs_ext    = {bus.lhs[TOTAL_WIDTH-1], bus.lhs};
      rhs_ext    = {bus.rhs[TOTAL_WIDTH-1], bus.rhs};
      lhs_mag    = lhs_ext[MW-1] ? -lhs_ext : lhs_ext;
      rhs_mag    = rhs_ext[MW-1] ? -rhs_ext : rhs_ext;
      rem_sh     = {rem[RW-2:0], dvd[N-1]};
      trial      = rem_sh - RW'(dvs);
      res_mag    = (SAT_W+1)'(dvd);
      res_signed = neg ? -res_mag : res_mag;
      sat        = saturate(res_signed, TOTAL_WIDTH);
   end

   // Bits that are structurally never needed: |lhs| never exceeds TOTAL_WIDTH bits here.
   assign unused_bits = ^{sat.value[SAT_W-1:TOTAL_WIDTH], lhs_mag[MW-1], rem[RW-1]};

   // Control FSM with registered handshake outputs and the division datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         dvd           <= '0;
         dvs           <= '0;
         rem           <= '0;
         cnt           <= '0;
         neg           <= 1'b0;
         lhs_neg       <= 1'b0;
         zero_div      <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.quotient  <= '0;
         bus.div_zero  <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  dvd          <= N'(lhs_mag[TOTAL_WIDTH-1:0]) << FRAC_WIDTH;
                  dvs          <= rhs_mag;
                  rem          <= '0;
                  cnt          <= CW'(N - 1);
                  neg          <= bus.lhs[TOTAL_WIDTH-1] ^ bus.rhs[TOTAL_WIDTH-1];
                  lhs_neg      <= bus.lhs[TOTAL_WIDTH-1];
                  zero_div     <= (bus.rhs == '0);
                  bus.in_ready <= 1'b0;
                  state        <= CALC;
               end
            end
            CALC: begin
               if (!trial[RW-1]) begin
                  rem <= trial;
                  dvd <= {dvd[N-2:0], 1'b1};
               end else begin
                  rem <= rem_sh;
                  dvd <= {dvd[N-2:0], 1'b0};
               end
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            FIX: begin
               if (zero_div) begin
                  bus.quotient <= lhs_neg ? Q_MIN : Q_MAX;
                  bus.div_zero <= 1'b1;
                  bus.overflow <= 1'b0;
               end else begin
                  bus.quotient <= sat.value[TOTAL_WIDTH-1:0];
                  bus.div_zero <= 1'b0;
                  bus.overflow <= sat.ovf;
               end
               state <= DONE;
            end
            DONE: begin
               // Result registers settle for one cycle before being presented.
               if (!bus.out_valid) begin
                  bus.out_valid <= 1'b1;
               end else if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_div_seq.sv
// Bench for fixed_div_seq: directed Q16.16 cases plus randomized pairs on Q16.16 and Q16.8 instances.
module tb_fixed_div_seq;

   localparam int TW_A = 32;
   localparam int FW_A = 16;
   localparam int TW_B = 24;
   localparam int FW_B = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fixed_div_seq_if #(.TOTAL_WIDTH(TW_A)) bus_a ();
   fixed_div_seq_if #(.TOTAL_WIDTH(TW_B)) bus_b ();

   fixed_div_seq #(.TOTAL_WIDTH(TW_A), .FRAC_WIDTH(FW_A)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   fixed_div_seq #(.TOTAL_WIDTH(TW_B), .FRAC_WIDTH(FW_B)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rd_in_ready(input int sel);
      return (sel != 0) ? bus_b.in_ready : bus_a.in_ready;
   endfunction

   function automatic logic rd_out_valid(input int sel);
      return (sel != 0) ? bus_b.out_valid : bus_a.out_valid;
   endfunction

   function automatic logic [63:0] rd_q(input int sel);
      return (sel != 0) ? 64'(bus_b.quotient) : 64'(bus_a.quotient);
   endfunction

   function automatic logic [1:0] rd_flags(input int sel);
      return (sel != 0) ? {bus_b.div_zero, bus_b.overflow} : {bus_a.div_zero, bus_a.overflow};
   endfunction

   task automatic drive_in(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b);
      if (sel != 0) begin
         bus_b.in_valid = v;
         bus_b.lhs      = a[TW_B-1:0];
         bus_b.rhs      = b[TW_B-1:0];
      end else begin
         bus_a.in_valid = v;
         bus_a.lhs      = a[TW_A-1:0];
         bus_a.rhs      = b[TW_A-1:0];
      end
   endtask

   task automatic set_out_ready(input int sel, input logic v);
      if (sel != 0) bus_b.out_ready = v;
      else          bus_a.out_ready = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Real-division reference: scale, truncate toward zero, saturate; divide by zero pins to a rail.
   task automatic ref_div(input int tw, input int fw, input logic [63:0] a_raw, input logic [63:0] b_raw,
                          output logic [63:0] q, output logic [1:0] flags);
      longint a, b, num, t, mx, mn;
      logic [63:0] mask;
      a    = $signed(a_raw << (64 - tw)) >>> (64 - tw);
      b    = $signed(b_raw << (64 - tw)) >>> (64 - tw);
      mx   = (longint'(1) <<< (tw - 1)) - 1;
      mn   = -mx - 1;
      mask = (64'd1 << tw) - 64'd1;
      if (b == 0) begin
         t     = (a >= 0) ? mx : mn;
         flags = 2'b10;
      end else begin
         num   = a * (longint'(1) <<< fw);
         t     = num / b;
         flags = 2'b00;
         if (t > mx) begin t = mx; flags = 2'b01; end
         if (t < mn) begin t = mn; flags = 2'b01; end
      end
      q = 64'(t) & mask;
   endtask

   // One full transaction; optional hold cycles with out_ready low while output must stay stable.
   task automatic do_op(input int sel, input logic [63:0] a, input logic [63:0] b, input int hold,
                        output logic [63:0] q, output logic [1:0] flags, output int lat);
      int w;
      w = 0;
      while (!rd_in_ready(sel) && w < 100) begin tick(); w++; end
      check("in_ready_before_op", 64'(rd_in_ready(sel)), 64'd1);
      drive_in(sel, 1'b1, a, b);
      tick();
      drive_in(sel, 1'b0, 64'd0, 64'd0);
      lat = 0;
      while (!rd_out_valid(sel) && lat < 200) begin tick(); lat++; end
      q     = rd_q(sel);
      flags = rd_flags(sel);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_stable", {rd_q(sel)[61:0], rd_flags(sel)}, {q[61:0], flags});
      end
      set_out_ready(sel, 1'b1);
      tick();
      set_out_ready(sel, 1'b0);
      check("out_valid_after_handshake", 64'(rd_out_valid(sel)), 64'd0);
   endtask

   // Run one operation and compare against a fixed expectation and the model.
   task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_q, input logic [1:0] exp_flags);
      logic [63:0] q, mq;
      logic [1:0]  f, mf;
      int          lat;
      do_op(0, a, b, 0, q, f, lat);
      ref_div(TW_A, FW_A, a, b, mq, mf);
      check({tag, "_q"}, q, exp_q);
      check({tag, "_flags"}, 64'(f), 64'(exp_flags));
      check({tag, "_model"}, {q[61:0], f}, {mq[61:0], mf});
      check({tag, "_latency"}, 64'(lat), 64'(TW_A + FW_A + 2));
   endtask

   task automatic random_run(input int sel, input int tw, input int fw, input int count);
      logic [63:0] a, b, q, mq, mask, mx;
      logic [1:0]  f, mf;
      int          lat;
      mask = (64'd1 << tw) - 64'd1;
      mx   = (64'd1 << (tw - 1)) - 64'd1;
      for (int i = 0; i < count; i++) begin
         a = {32'($urandom), 32'($urandom)} & mask;
         b = {32'($urandom), 32'($urandom)} & mask;
         case ($urandom_range(0, 9))
            0: b = 64'd0;
            1: b = 64'($urandom_range(1, 255));
            2: b = (64'd0 - 64'($urandom_range(1, 255))) & mask;
            3: a = 64'($urandom_range(0, 4095));
            4: a = (mx + 64'd1) & mask;
            5: b = 64'($urandom_range(1, 1 << fw)) << 4;
            default: ;
         endcase
         do_op(sel, a, b, 0, q, f, lat);
         ref_div(tw, fw, a, b, mq, mf);
         check($sformatf("rand%0d_%0d_result a=%0h b=%0h", sel, i, a, b), {q[61:0], f}, {mq[61:0], mf});
         check($sformatf("rand%0d_%0d_latency", sel, i), 64'(lat), 64'(tw + fw + 2));
      end
   endtask

   initial begin
      logic [63:0] q;
      logic [1:0]  f;
      int          lat;

      reset = 1'b1;
      drive_in(0, 1'b0, 64'd0, 64'd0);
      drive_in(1, 1'b0, 64'd0, 64'd0);
      set_out_ready(0, 1'b0);
      set_out_ready(1, 1'b0);
      repeat (3) tick();
      check("reset_in_ready", 64'(bus_a.in_ready), 64'd1);
      check("reset_out_valid", 64'(bus_a.out_valid), 64'd0);
      check("reset_quotient", 64'(bus_a.quotient), 64'd0);
      check("reset_flags", 64'(rd_flags(0)), 64'd0);
      check("reset_b_in_ready", 64'(bus_b.in_ready), 64'd1);
      reset = 1'b0;
      tick();

      directed("div_6_2",      64'h0006_0000, 64'h0002_0000, 64'h0003_0000, 2'b00);
      directed("div_1_3",      64'h0001_0000, 64'h0003_0000, 64'h0000_5555, 2'b00);
      directed("div_m1_3",     64'hFFFF_0000, 64'h0003_0000, 64'hFFFF_AAAB, 2'b00);
      directed("div_m7p5_2",   64'hFFF8_8000, 64'h0002_0000, 64'hFFFC_4000, 2'b00);
      directed("sat_pos",      64'h4000_0000, 64'h0000_0001, 64'h7FFF_FFFF, 2'b01);
      directed("min_exact",    64'h8000_0000, 64'h0001_0000, 64'h8000_0000, 2'b00);
      directed("sat_min_neg1", 64'h8000_0000, 64'hFFFF_0000, 64'h7FFF_FFFF, 2'b01);
      directed("dz_pos",       64'h0005_0000, 64'h0000_0000, 64'h7FFF_FFFF, 2'b10);
      directed("dz_neg",       64'hFFFB_0000, 64'h0000_0000, 64'h8000_0000, 2'b10);
      directed("dz_zero",      64'h0000_0000, 64'h0000_0000, 64'h7FFF_FFFF, 2'b10);
      directed("neg_zero",     64'hFFFF_FFFF, 64'h7FFF_FFFF, 64'h0000_0000, 2'b00);

      // Backpressure: result held for 10 cycles while a new operand pair is offered.
      drive_in(0, 1'b1, 64'h0008_0000, 64'h0002_0000);
      tick();
      drive_in(0, 1'b0, 64'd0, 64'd0);
      lat = 0;
      while (!bus_a.out_valid && lat < 200) begin tick(); lat++; end
      check("bp_latency", 64'(lat), 64'd50);
      check("bp_q", 64'(bus_a.quotient), 64'h0004_0000);
      drive_in(0, 1'b1, 64'h0001_0000, 64'h0003_0000);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_hold_q", 64'(bus_a.quotient), 64'h0004_0000);
         check("bp_hold_state", {62'd0, bus_a.out_valid, bus_a.in_ready}, 64'b10);
         check("bp_hold_flags", 64'(rd_flags(0)), 64'd0);
      end
      set_out_ready(0, 1'b1);
      tick();
      set_out_ready(0, 1'b0);
      check("bp_after_hs", {62'd0, bus_a.out_valid, bus_a.in_ready}, 64'b01);
      tick();
      drive_in(0, 1'b0, 64'd0, 64'd0);
      check("bp_accepted_next", 64'(bus_a.in_ready), 64'd0);
      lat = 0;
      while (!bus_a.out_valid && lat < 200) begin tick(); lat++; end
      check("bp_second_latency", 64'(lat), 64'd50);
      check("bp_second_q", 64'(bus_a.quotient), 64'h0000_5555);
      set_out_ready(0, 1'b1);
      tick();
      set_out_ready(0, 1'b0);

      // Reset in the middle of CALC aborts the operation.
      drive_in(0, 1'b1, 64'h0001_0000, 64'h0003_0000);
      tick();
      drive_in(0, 1'b0, 64'd0, 64'd0);
      repeat (20) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_state", {62'd0, bus_a.out_valid, bus_a.in_ready}, 64'b01);
      check("abort_quotient", 64'(bus_a.quotient), 64'd0);
      repeat (60) begin
         tick();
         check("abort_no_result", 64'(bus_a.out_valid), 64'd0);
      end
      do_op(0, 64'h0006_0000, 64'h0002_0000, 3, q, f, lat);
      check("after_abort_q", q, 64'h0003_0000);
      check("after_abort_latency", 64'(lat), 64'd50);

      random_run(0, TW_A, FW_A, 600);
      random_run(1, TW_B, FW_B, 600);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
